// File: rtl/seq_arith_4x1b_decr.sv
// seq_arith_4x1b_decr
//
// Bit-serial NBITS-wide decrementer. A serial stream of NBITS-bit words
// arrives LSB first. Each word minus one leaves on the serial output in the
// same cycle. Each result is also collected into a parallel register and
// flagged with a one-cycle valid pulse.
//
// Build option:
//   SEQ_ARITH_DECR_UNDERFLOW_EN  when defined, underflow pulses with word_val
//                                if the input word was zero. When undefined,
//                                underflow is tied low. The port list is the
//                                same in both builds.
//
// Ports:
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   in_val     in   1      serial bit valid; bit consumed only when high
//   in_        in   1      serial data bit, LSB first
//   start      in   1      with in_val, marks this bit as bit 0 of a new word
//   out_val    out  1      serial output valid (follows in_val)
//   out        out  1      serial difference bit
//   word       out  NBITS  last completed decremented word (registered)
//   word_val   out  1      one-cycle pulse: word just updated
//   underflow  out  1      one-cycle pulse with word_val: input word was 0

module seq_arith_4x1b_decr #(
    parameter int unsigned NBITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    input  logic             in_,
    input  logic             start,
    output logic             out_val,
    output logic             out,
    output logic [NBITS-1:0] word,
    output logic             word_val,
    output logic             underflow
);

    localparam int unsigned CW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NBITS - 1);

    logic             borrow;
    logic [CW-1:0]    count;
    logic [NBITS-2:0] shift;

    logic             b0;
    logic             eb;
    logic             last;
    logic             borrow_nxt;
    logic [NBITS-1:0] cat;

    always_comb begin
        b0         = start | (count == '0);
        // Bit 0 always starts with a borrow of one.
        eb         = b0 | borrow;
        last       = (count == LAST_IDX) & ~start;
        borrow_nxt = eb & ~in_;
        out_val    = in_val & ~reset;
        out        = in_val & ~reset & (in_ ^ eb);
        cat        = {out, shift};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            borrow   <= 1'b1;
            count    <= '0;
            shift    <= '0;
            word     <= '0;
            word_val <= 1'b0;
        end else begin
            word_val <= 1'b0;
            if (in_val) begin
                // Bits enter at the top and move down, so bit 0 ends at index 0.
                shift <= cat[NBITS-1:1];
                if (last) begin
                    word     <= cat;
                    word_val <= 1'b1;
                    count    <= '0;
                    borrow   <= 1'b1;
                end else begin
                    count  <= (b0 ? '0 : count) + CW'(1);
                    borrow <= borrow_nxt;
                end
            end
        end
    end

`ifdef SEQ_ARITH_DECR_UNDERFLOW_EN
    logic underflow_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= in_val & last & borrow_nxt;
        end
    end

    assign underflow = underflow_q;
`else
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_seq_arith_4x1b_decr.sv
module tb_seq_arith_4x1b_decr;

    logic       clk;
    logic       reset;
    logic       in_val;
    logic       in_;
    logic       start;
    logic       out_val;
    logic       out;
    logic [3:0] word;
    logic       word_val;
    logic       underflow;

    int checks;
    int errors;

`ifdef SEQ_ARITH_DECR_UNDERFLOW_EN
    localparam logic EXP_UF = 1'b1;
`else
    localparam logic EXP_UF = 1'b0;
`endif

    seq_arith_4x1b_decr #(.NBITS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_val    (in_val),
        .in_       (in_),
        .start     (start),
        .out_val   (out_val),
        .out       (out),
        .word      (word),
        .word_val  (word_val),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic b, input logic s);
        @(negedge clk);
        in_val = v;
        in_    = b;
        start  = s;
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        in_val = 1'b1;
        in_    = 1'b1;
        start  = 1'b0;
        #3;
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val: got %b expected 0", out_val); end
        checks++; if (out !== 1'b0) begin errors++; $display("FAIL reset_out: got %b expected 0", out); end
        checks++; if (word !== 4'h0) begin errors++; $display("FAIL reset_word: got %0h expected 0", word); end
        checks++; if (word_val !== 1'b0) begin errors++; $display("FAIL reset_word_val: got %b expected 0", word_val); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
        @(negedge clk);
        @(negedge clk);
        in_val = 1'b0;
        in_    = 1'b0;
        reset  = 1'b0;
    endtask

    task automatic test_basic;
        logic [3:0] bits;
        logic [3:0] exp;
        bits = 4'h5;
        exp  = 4'h4;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, bits[i], 1'b0);
            #1;
            checks++; if (out !== exp[i]) begin errors++; $display("FAIL basic_out[%0d]: got %b expected %b", i, out, exp[i]); end
            checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL basic_out_val[%0d]: got %b expected 1", i, out_val); end
        end
        @(posedge clk); #1;
        in_val = 1'b0;
        checks++; if (word_val !== 1'b1) begin errors++; $display("FAIL basic_word_val: got %b expected 1", word_val); end
        checks++; if (word !== 4'h4) begin errors++; $display("FAIL basic_word: got %0h expected 4", word); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL basic_underflow: got %b expected 0", underflow); end
        @(posedge clk); #1;
        checks++; if (word_val !== 1'b0) begin errors++; $display("FAIL basic_word_val_drop: got %b expected 0", word_val); end
    endtask

    task automatic test_zero;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            #1;
            checks++; if (out !== 1'b1) begin errors++; $display("FAIL zero_out[%0d]: got %b expected 1", i, out); end
        end
        @(posedge clk); #1;
        in_val = 1'b0;
        checks++; if (word_val !== 1'b1) begin errors++; $display("FAIL zero_word_val: got %b expected 1", word_val); end
        checks++; if (word !== 4'hf) begin errors++; $display("FAIL zero_word: got %0h expected f", word); end
        checks++; if (underflow !== EXP_UF) begin errors++; $display("FAIL zero_underflow: got %b expected %b", underflow, EXP_UF); end
        @(posedge clk); #1;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL zero_underflow_drop: got %b expected 0", underflow); end
        checks++; if (word_val !== 1'b0) begin errors++; $display("FAIL zero_word_val_drop: got %b expected 0", word_val); end
    endtask

    task automatic test_back_to_back;
        logic [11:0] bits;
        logic [11:0] exp;
        logic [3:0]  exp_word;
        bits = 12'h718;   // words 8, 1, 7 (first word in low nibble)
        exp  = 12'h607;   // results 7, 0, 6
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, bits[k], 1'b0);
            #1;
            checks++; if (out !== exp[k]) begin errors++; $display("FAIL b2b_out[%0d]: got %b expected %b", k, out, exp[k]); end
            @(posedge clk); #1;
            checks++;
            if (word_val !== ((k % 4) == 3)) begin
                errors++; $display("FAIL b2b_word_val[%0d]: got %b expected %b", k, word_val, ((k % 4) == 3));
            end
            if ((k % 4) == 3) begin
                exp_word = exp[(k - 3) +: 4];
                checks++; if (word !== exp_word) begin errors++; $display("FAIL b2b_word[%0d]: got %0h expected %0h", k, word, exp_word); end
                checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL b2b_underflow[%0d]: got %b expected 0", k, underflow); end
            end
        end
        in_val = 1'b0;
    endtask

    task automatic test_gaps;
        logic [3:0] bits;
        logic [3:0] exp;
        bits = 4'h6;
        exp  = 4'h5;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, bits[i], 1'b0);
            #1;
            checks++; if (out !== exp[i]) begin errors++; $display("FAIL gaps_out[%0d]: got %b expected %b", i, out, exp[i]); end
            @(posedge clk); #1;
            checks++; if (word_val !== (i == 3)) begin errors++; $display("FAIL gaps_word_val[%0d]: got %b expected %b", i, word_val, (i == 3)); end
            drive(1'b0, 1'b1, 1'b0);
            #1;
            checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL gaps_out_val[%0d]: got %b expected 0", i, out_val); end
            checks++; if (out !== 1'b0) begin errors++; $display("FAIL gaps_idle_out[%0d]: got %b expected 0", i, out); end
            @(posedge clk); #1;
            checks++; if (word_val !== 1'b0) begin errors++; $display("FAIL gaps_hold_word_val[%0d]: got %b expected 0", i, word_val); end
        end
        checks++; if (word !== 4'h5) begin errors++; $display("FAIL gaps_word: got %0h expected 5", word); end
    endtask

    task automatic test_start_realign;
        logic [3:0] bits;
        logic [3:0] exp;
        bits = 4'h3;
        exp  = 4'h2;
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, bits[i], (i == 0));
            #1;
            checks++; if (out !== exp[i]) begin errors++; $display("FAIL start_out[%0d]: got %b expected %b", i, out, exp[i]); end
            @(posedge clk); #1;
            checks++; if (word_val !== (i == 3)) begin errors++; $display("FAIL start_word_val[%0d]: got %b expected %b", i, word_val, (i == 3)); end
        end
        in_val = 1'b0;
        start  = 1'b0;
        checks++; if (word !== 4'h2) begin errors++; $display("FAIL start_word: got %0h expected 2", word); end
    endtask

    task automatic test_reset_mid_word;
        logic [3:0] bits;
        logic [3:0] exp;
        bits = 4'h9;
        exp  = 4'h8;
        drive(1'b1, bits[0], 1'b0);
        drive(1'b1, bits[1], 1'b0);
        @(negedge clk);
        in_val = 1'b1;
        in_    = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL rst_mid_out_val: got %b expected 0", out_val); end
        checks++; if (out !== 1'b0) begin errors++; $display("FAIL rst_mid_out: got %b expected 0", out); end
        checks++; if (word_val !== 1'b0) begin errors++; $display("FAIL rst_mid_word_val: got %b expected 0", word_val); end
        checks++; if (word !== 4'h0) begin errors++; $display("FAIL rst_mid_word: got %0h expected 0", word); end
        @(negedge clk);
        in_val = 1'b0;
        in_    = 1'b0;
        reset  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, bits[i], 1'b0);
            #1;
            checks++; if (out !== exp[i]) begin errors++; $display("FAIL rst_resend_out[%0d]: got %b expected %b", i, out, exp[i]); end
            @(posedge clk); #1;
            checks++; if (word_val !== (i == 3)) begin errors++; $display("FAIL rst_resend_word_val[%0d]: got %b expected %b", i, word_val, (i == 3)); end
        end
        in_val = 1'b0;
        checks++; if (word !== 4'h8) begin errors++; $display("FAIL rst_resend_word: got %0h expected 8", word); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_basic;
        test_zero;
        test_back_to_back;
        test_gaps;
        test_start_realign;
        test_reset_mid_word;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
